// File: rtl/verifica_pin.sv
// PIN verifier: checks captured keypad PINs against a stored master PIN, paces
// a lockout after repeated failures and lets upstream logic reprogram the master.
module verifica_pin #(
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned LOCK_TICKS  = 30,
  parameter logic [15:0] DEFAULT_PIN = 16'h1234
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [16:0]                      pin_in,
  input  logic                             tick_1hz,
  input  logic                             prog_en,
  output logic                             granted,
  output logic                             denied,
  output logic                             prog_done,
  output logic                             locked_out,
  output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left,
  output logic [7:0]                       lock_remain
);

  localparam int unsigned       TriesW    = $clog2(MAX_TRIES + 1);
  localparam logic [TriesW-1:0] MaxTries  = TriesW'(MAX_TRIES);
  localparam logic [7:0]        LockTicks = 8'(LOCK_TICKS);

  typedef enum logic [1:0] {StIdle, StCheck, StResult, StLockout} state_e;
  typedef enum logic [1:0] {OutNone, OutGrant, OutDeny, OutProg} outcome_e;

  state_e              state_q, state_d;
  outcome_e            outcome_q, outcome_d;
  logic                status_q;
  logic [15:0]         digits_q, digits_d;
  logic                prog_q, prog_d;
  logic [15:0]         master_q, master_d;
  logic [TriesW-1:0]   fail_cnt_q, fail_cnt_d;
  logic [TriesW-1:0]   tries_left_q, tries_left_d;
  logic [7:0]          lock_remain_q, lock_remain_d;
  logic                granted_q, granted_d;
  logic                denied_q, denied_d;
  logic                prog_done_q, prog_done_d;

  logic status_rise;
  logic digits_valid;

  assign status_rise  = pin_in[16] & ~status_q;
  assign digits_valid = (digits_q[15:12] <= 4'd9) && (digits_q[11:8] <= 4'd9) &&
                        (digits_q[7:4]   <= 4'd9) && (digits_q[3:0]  <= 4'd9);

  always_comb begin
    state_d       = state_q;
    outcome_d     = outcome_q;
    digits_d      = digits_q;
    prog_d        = prog_q;
    master_d      = master_q;
    fail_cnt_d    = fail_cnt_q;
    tries_left_d  = tries_left_q;
    lock_remain_d = lock_remain_q;
    granted_d     = 1'b0;
    denied_d      = 1'b0;
    prog_done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (status_rise) begin
          digits_d = pin_in[15:0];
          prog_d   = prog_en;
          state_d  = StCheck;
        end
      end

      StCheck: begin
        state_d = StResult;
        if (prog_q) begin
          // Reprogramming never touches the failure counter, valid or not.
          if (digits_valid) begin
            master_d  = digits_q;
            outcome_d = OutProg;
          end else begin
            outcome_d = OutDeny;
          end
        end else if (digits_valid && (digits_q == master_q)) begin
          outcome_d  = OutGrant;
          fail_cnt_d = '0;
        end else begin
          outcome_d  = OutDeny;
          fail_cnt_d = fail_cnt_q + 1'b1;
        end
      end

      StResult: begin
        granted_d    = (outcome_q == OutGrant);
        denied_d     = (outcome_q == OutDeny);
        prog_done_d  = (outcome_q == OutProg);
        tries_left_d = MaxTries - fail_cnt_q;
        if (fail_cnt_q == MaxTries) begin
          // Loading here means a tick in this same cycle is simply lost.
          state_d       = StLockout;
          lock_remain_d = LockTicks;
        end else begin
          state_d = StIdle;
        end
      end

      StLockout: begin
        if (tick_1hz) begin
          lock_remain_d = lock_remain_q - 8'd1;
          if (lock_remain_q <= 8'd1) begin
            lock_remain_d = 8'd0;
            state_d       = StIdle;
            fail_cnt_d    = '0;
            tries_left_d  = MaxTries;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      outcome_q     <= OutNone;
      status_q      <= 1'b0;
      digits_q      <= '0;
      prog_q        <= 1'b0;
      master_q      <= DEFAULT_PIN;
      fail_cnt_q    <= '0;
      tries_left_q  <= MaxTries;
      lock_remain_q <= 8'd0;
      granted_q     <= 1'b0;
      denied_q      <= 1'b0;
      prog_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      outcome_q     <= outcome_d;
      status_q      <= pin_in[16];
      digits_q      <= digits_d;
      prog_q        <= prog_d;
      master_q      <= master_d;
      fail_cnt_q    <= fail_cnt_d;
      tries_left_q  <= tries_left_d;
      lock_remain_q <= lock_remain_d;
      granted_q     <= granted_d;
      denied_q      <= denied_d;
      prog_done_q   <= prog_done_d;
    end
  end

  assign granted     = granted_q;
  assign denied      = denied_q;
  assign prog_done   = prog_done_q;
  assign locked_out  = (state_q == StLockout);
  assign tries_left  = tries_left_q;
  assign lock_remain = lock_remain_q;

  pulses_exclusive_a : assert property (@(posedge clock) disable iff (!reset)
    $onehot0({granted, denied, prog_done}));

  lock_count_consistent_a : assert property (@(posedge clock) disable iff (!reset)
    locked_out == (lock_remain != 8'd0));

endmodule

// File: tb/tb_verifica_pin.sv
// Randomized bench for verifica_pin, checked against a transaction-level model
// of the PIN/lockout rules.
module tb_verifica_pin;

  localparam int MaxTries  = 3;
  localparam int LockTicks = 30;

  logic        clock;
  logic        reset;
  logic [16:0] pin_in;
  logic        tick_1hz;
  logic        prog_en;
  logic        granted;
  logic        denied;
  logic        prog_done;
  logic        locked_out;
  logic [1:0]  tries_left;
  logic [7:0]  lock_remain;

  verifica_pin #(
    .MAX_TRIES  (MaxTries),
    .LOCK_TICKS (LockTicks),
    .DEFAULT_PIN(16'h1234)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .pin_in     (pin_in),
    .tick_1hz   (tick_1hz),
    .prog_en    (prog_en),
    .granted    (granted),
    .denied     (denied),
    .prog_done  (prog_done),
    .locked_out (locked_out),
    .tries_left (tries_left),
    .lock_remain(lock_remain)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [15:0] m_master;
  int          m_fails;
  bit          m_locked;
  int          m_remain;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic bit pin_valid(input logic [15:0] p);
    for (int i = 0; i < 4; i++) if (p[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_master = 16'h1234;
    m_fails  = 0;
    m_locked = 1'b0;
    m_remain = 0;
  endtask

  task automatic model_tick();
    if (m_locked) begin
      m_remain--;
      if (m_remain == 0) begin
        m_locked = 1'b0;
        m_fails  = 0;
      end
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".tries_left"}, int'(tries_left), MaxTries - m_fails);
    check({tag, ".locked_out"}, int'(locked_out), int'(m_locked));
    check({tag, ".lock_remain"}, int'(lock_remain), m_locked ? m_remain : 0);
  endtask

  // Present one PIN, hold status for `hold` clocks; optionally pulse tick so that
  // it is sampled on the same edge as the result pulse.
  task automatic txn(input string tag, input logic [15:0] pin, input logic prog,
                     input int hold, input bit tick_k2);
    int kind;  // 0 none, 1 grant, 2 deny, 3 prog
    int g_n, d_n, p_n, g_at, d_at, p_at, last;
    kind = 0;
    if (m_locked) begin
      if (tick_k2) model_tick();
    end else if (prog) begin
      if (pin_valid(pin)) begin
        m_master = pin;
        kind     = 3;
      end else begin
        kind = 2;
      end
    end else if (pin_valid(pin) && pin == m_master) begin
      kind    = 1;
      m_fails = 0;
    end else begin
      kind = 2;
      m_fails++;
      if (m_fails == MaxTries) begin
        m_locked = 1'b1;
        m_remain = LockTicks;
      end
    end

    g_n = 0; d_n = 0; p_n = 0; g_at = -1; d_at = -1; p_at = -1;
    pin_in  = {1'b1, pin};
    prog_en = prog;
    last    = ((hold > 3) ? hold : 3) + 1;
    for (int c = 0; c <= last; c++) begin
      @(posedge clock); #1;
      if (granted)   begin g_n++; g_at = c; end
      if (denied)    begin d_n++; d_at = c; end
      if (prog_done) begin p_n++; p_at = c; end
      if (c == hold - 1) pin_in[16] = 1'b0;
      tick_1hz = tick_k2 && (c == 1);
    end
    prog_en  = 1'b0;
    tick_1hz = 1'b0;

    check({tag, ".granted_cnt"}, g_n, (kind == 1) ? 1 : 0);
    check({tag, ".denied_cnt"}, d_n, (kind == 2) ? 1 : 0);
    check({tag, ".prog_done_cnt"}, p_n, (kind == 3) ? 1 : 0);
    if (kind == 1) check({tag, ".granted_cycle"}, g_at, 2);
    if (kind == 2) check({tag, ".denied_cycle"}, d_at, 2);
    if (kind == 3) check({tag, ".prog_done_cycle"}, p_at, 2);
    check_state(tag);
  endtask

  task automatic ticks(input string tag, input int n, input bit each);
    for (int i = 0; i < n; i++) begin
      tick_1hz = 1'b1;
      @(posedge clock); #1;
      tick_1hz = 1'b0;
      model_tick();
      repeat ($urandom_range(0, 3)) begin
        @(posedge clock); #1;
      end
      if (each) check_state(tag);
    end
    check_state(tag);
  endtask

  task automatic do_reset(input string tag);
    pin_in   = '0;
    prog_en  = 1'b0;
    tick_1hz = 1'b0;
    reset    = 1'b0;
    model_reset();
    #1;
    check({tag, ".granted"}, int'(granted), 0);
    check({tag, ".denied"}, int'(denied), 0);
    check({tag, ".prog_done"}, int'(prog_done), 0);
    check_state(tag);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  function automatic logic [15:0] rand_digits(input bit allow_bad);
    logic [15:0] p;
    for (int i = 0; i < 4; i++) p[4*i +: 4] = 4'($urandom_range(0, 9));
    if (allow_bad) p[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
    return p;
  endfunction

  initial begin
    logic [15:0] p;
    int          r;
    reset    = 1'b0;
    pin_in   = '0;
    prog_en  = 1'b0;
    tick_1hz = 1'b0;
    @(posedge clock); #1;
    do_reset("reset");

    txn("grant_default", 16'h1234, 1'b0, 1, 1'b0);

    txn("wrong1", 16'h9999, 1'b0, 2, 1'b0);
    txn("wrong2", 16'h9999, 1'b0, 1, 1'b0);
    txn("wrong3", 16'h9999, 1'b0, 3, 1'b1);
    ticks("lock_a", 5, 1'b1);
    txn("locked_pin", 16'h1234, 1'b0, 2, 1'b0);
    ticks("lock_b", 25, 1'b1);

    txn("prog_5678", 16'h5678, 1'b1, 1, 1'b0);
    txn("old_master", 16'h1234, 1'b0, 1, 1'b0);
    txn("new_master", 16'h5678, 1'b0, 1, 1'b0);
    txn("prog_bad", 16'h5A78, 1'b1, 1, 1'b0);
    txn("digit_a_hold", 16'h12A4, 1'b0, 20, 1'b0);
    txn("digit_a_d1", 16'hA234, 1'b0, 1, 1'b0);

    txn("relock1", 16'h0000, 1'b0, 1, 1'b0);
    txn("relock2", 16'h0000, 1'b0, 1, 1'b0);
    ticks("relocked", 3, 1'b0);
    do_reset("reset_mid_lock");
    txn("grant_after_reset", 16'h1234, 1'b0, 1, 1'b0);

    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 3)      p = m_master;
      else if (r <= 6) p = rand_digits(1'b0);
      else if (r <= 8) p = rand_digits(1'b1);
      else             p = 16'($urandom());
      txn("rand", p, ($urandom_range(0, 15) == 0), $urandom_range(1, 6),
          ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) ticks("rand_tick", $urandom_range(1, 12), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
